// File: rtl/cntr_multimode.sv
// Multimode counter: prescaled up/down/bounce/hold stepping
// with wrap or saturate, synchronous load and registered pulses.
module cntr_multimode #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  sat,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      max_val,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic [PRESCALE_W-1:0] presc,
    output logic [WIDTH-1:0]      count,
    output logic                  dir,
    output logic                  tc,
    output logic                  cmp_match
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [WIDTH-1:0]      ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] P_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] p;
    logic [PRESCALE_W-1:0] p_nxt;
    logic [WIDTH-1:0]      count_nxt;
    logic                  dir_nxt;
    logic                  tc_nxt;
    logic                  cmp_nxt;
    logic                  tick;
    logic                  term;

    always_comb begin
        tick      = en && (p == presc);
        p_nxt     = p;
        count_nxt = count;
        dir_nxt   = dir;
        tc_nxt    = 1'b0;
        cmp_nxt   = 1'b0;
        term      = 1'b0;

        if (en) begin
            p_nxt = tick ? '0 : p + P_ONE;
        end

        // Fixed-direction modes pin dir even while disabled
        if (mode == MODE_UP) begin
            dir_nxt = 1'b0;
        end else if (mode == MODE_DOWN) begin
            dir_nxt = 1'b1;
        end

        if (load) begin
            count_nxt = load_val;
            p_nxt     = '0;
            cmp_nxt   = (load_val == cmp_val);
        end else if (tick && mode != MODE_HOLD) begin
            unique case (mode)
                MODE_UP: begin
                    term = (count >= max_val);
                    if (term) begin
                        count_nxt = sat ? max_val : '0;
                    end else begin
                        count_nxt = count + ONE;
                    end
                end
                MODE_DOWN: begin
                    term = (count == '0);
                    if (term) begin
                        count_nxt = sat ? '0 : max_val;
                    end else begin
                        count_nxt = count - ONE;
                    end
                end
                MODE_BOUNCE: begin
                    // Out-of-range (e.g. after a load) snaps to the top
                    if (count > max_val) begin
                        term      = !dir;
                        count_nxt = max_val;
                        dir_nxt   = 1'b1;
                    end else if (!dir) begin
                        term = (count == max_val);
                        if (term) begin
                            dir_nxt   = 1'b1;
                            count_nxt = (max_val == '0) ? '0 : max_val - ONE;
                        end else begin
                            count_nxt = count + ONE;
                        end
                    end else begin
                        term = (count == '0);
                        if (term) begin
                            dir_nxt   = 1'b0;
                            count_nxt = (max_val == '0) ? '0 : ONE;
                        end else begin
                            count_nxt = count - ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
            tc_nxt  = term;
            cmp_nxt = (count_nxt == cmp_val);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p         <= '0;
            count     <= '0;
            dir       <= 1'b0;
            tc        <= 1'b0;
            cmp_match <= 1'b0;
        end else begin
            p         <= p_nxt;
            count     <= count_nxt;
            dir       <= dir_nxt;
            tc        <= tc_nxt;
            cmp_match <= cmp_nxt;
        end
    end

endmodule

// File: tb/tb_cntr_multimode.sv
// Bench for cntr_multimode: directed vector table, hand sequences,
// and randomized stimulus against an integer reference model.
module tb_cntr_multimode;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sat;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] max_val;
    logic [7:0] cmp_val;
    logic [3:0] presc;
    logic [7:0] count;
    logic       dir;
    logic       tc;
    logic       cmp_match;

    int nvec = 0;
    int nerr = 0;

    cntr_multimode #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat),
        .load(load), .load_val(load_val), .max_val(max_val),
        .cmp_val(cmp_val), .presc(presc), .count(count), .dir(dir),
        .tc(tc), .cmp_match(cmp_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       sat;
        logic       load;
        logic [7:0] lv;
        logic [7:0] mx;
        logic [7:0] cv;
        logic [3:0] pr;
        logic [7:0] ec;
        logic       ed;
        logic       et;
        logic       em;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, int r, int e, int md, int s,
                                int ld, int lv, int mx, int cv, int pr,
                                int ec, int ed, int et, int em);
        vec_t v;
        v.nm = nm;
        v.rst = 1'(r);
        v.en = 1'(e);
        v.mode = 2'(md);
        v.sat = 1'(s);
        v.load = 1'(ld);
        v.lv = 8'(lv);
        v.mx = 8'(mx);
        v.cv = 8'(cv);
        v.pr = 4'(pr);
        v.ec = 8'(ec);
        v.ed = 1'(ed);
        v.et = 1'(et);
        v.em = 1'(em);
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, int ec, int ed, int et, int em);
        nvec++;
        if (count !== 8'(ec) || dir !== 1'(ed) ||
            tc !== 1'(et) || cmp_match !== 1'(em)) begin
            nerr++;
            $display("FAIL %s: got count=%0d dir=%0b tc=%0b cmp=%0b, want count=%0d dir=%0d tc=%0d cmp=%0d",
                     nm, count, dir, tc, cmp_match, ec, ed, et, em);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, plain integers
    int m_count, m_dir, m_p, m_tc, m_cmp;

    task automatic model_step();
        int nc, nd, np, t, stepped, tk;
        if (rst) begin
            m_count = 0; m_dir = 0; m_p = 0; m_tc = 0; m_cmp = 0;
            return;
        end
        nc = m_count;
        nd = (mode == 0) ? 0 : (mode == 1) ? 1 : m_dir;
        t = 0;
        stepped = 0;
        tk = (en && m_p == int'(presc)) ? 1 : 0;
        np = en ? (tk ? 0 : (m_p + 1) % 16) : m_p;
        if (load) begin
            nc = load_val;
            np = 0;
            m_cmp = (nc == int'(cmp_val)) ? 1 : 0;
        end else if (tk && mode != 3) begin
            stepped = 1;
            if (mode == 0) begin
                if (m_count >= int'(max_val)) begin
                    t = 1; nc = sat ? int'(max_val) : 0;
                end else nc = m_count + 1;
            end else if (mode == 1) begin
                if (m_count == 0) begin
                    t = 1; nc = sat ? 0 : int'(max_val);
                end else nc = m_count - 1;
            end else if (m_count > int'(max_val)) begin
                t = (m_dir == 0) ? 1 : 0;
                nc = max_val; nd = 1;
            end else if (m_dir == 0) begin
                if (m_count == int'(max_val)) begin
                    t = 1; nd = 1;
                    nc = (max_val == 0) ? 0 : int'(max_val) - 1;
                end else nc = m_count + 1;
            end else begin
                if (m_count == 0) begin
                    t = 1; nd = 0;
                    nc = (max_val == 0) ? 0 : 1;
                end else nc = m_count - 1;
            end
        end
        if (!load) m_cmp = (stepped && nc == int'(cmp_val)) ? 1 : 0;
        m_tc = t;
        m_count = nc;
        m_dir = nd;
        m_p = np;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; sat = 1'b0; load = 1'b0;
        load_val = '0; max_val = '0; cmp_val = '0; presc = '0;

        // Up count with wrap
        add("up_rst", 1,1,0,0,0,0,5,3,0, 0,0,0,0);
        add("up_1",   0,1,0,0,0,0,5,3,0, 1,0,0,0);
        add("up_2",   0,1,0,0,0,0,5,3,0, 2,0,0,0);
        add("up_3",   0,1,0,0,0,0,5,3,0, 3,0,0,1);
        add("up_4",   0,1,0,0,0,0,5,3,0, 4,0,0,0);
        add("up_5",   0,1,0,0,0,0,5,3,0, 5,0,0,0);
        add("up_wrap",0,1,0,0,0,0,5,3,0, 0,0,1,0);
        add("up_1b",  0,1,0,0,0,0,5,3,0, 1,0,0,0);
        // Down with wrap after a load
        add("dn_rst", 1,1,1,0,0,0,4,0,0, 0,0,0,0);
        add("dn_load",0,1,1,0,1,2,4,0,0, 2,1,0,0);
        add("dn_1",   0,1,1,0,0,2,4,0,0, 1,1,0,0);
        add("dn_0",   0,1,1,0,0,2,4,0,0, 0,1,0,1);
        add("dn_wrap",0,1,1,0,0,2,4,0,0, 4,1,1,0);
        add("dn_3",   0,1,1,0,0,2,4,0,0, 3,1,0,0);
        // Bounce from reset
        add("bn_rst", 1,1,2,0,0,0,3,2,0, 0,0,0,0);
        add("bn_1",   0,1,2,0,0,0,3,2,0, 1,0,0,0);
        add("bn_2",   0,1,2,0,0,0,3,2,0, 2,0,0,1);
        add("bn_3",   0,1,2,0,0,0,3,2,0, 3,0,0,0);
        add("bn_top", 0,1,2,0,0,0,3,2,0, 2,1,1,1);
        add("bn_1d",  0,1,2,0,0,0,3,2,0, 1,1,0,0);
        add("bn_0d",  0,1,2,0,0,0,3,2,0, 0,1,0,0);
        add("bn_bot", 0,1,2,0,0,0,3,2,0, 1,0,1,0);
        add("bn_2u",  0,1,2,0,0,0,3,2,0, 2,0,0,1);
        // Reset beats load; load above max
        add("rst_ld", 1,1,0,0,1,7,5,9,0, 0,0,0,0);
        add("ld_9",   0,1,0,0,1,9,5,9,0, 9,0,0,1);
        add("ovr_tc", 0,1,0,0,0,9,5,9,0, 0,0,1,0);
        // Load vs tick and prescaler clear
        add("lt_rst", 1,1,0,0,0,0,5,3,2, 0,0,0,0);
        add("lt_ld5", 0,1,0,0,1,5,5,3,2, 5,0,0,0);
        add("lt_p1",  0,1,0,0,0,5,5,3,2, 5,0,0,0);
        add("lt_p2",  0,1,0,0,0,5,5,3,2, 5,0,0,0);
        add("lt_ldtk",0,1,0,0,1,3,5,3,2, 3,0,0,1);
        add("lt_q0",  0,1,0,0,0,3,5,3,2, 3,0,0,0);
        add("lt_ldp", 0,1,0,0,1,3,5,3,2, 3,0,0,1);
        add("lt_q1",  0,1,0,0,0,3,5,3,2, 3,0,0,0);
        add("lt_q2",  0,1,0,0,0,3,5,3,2, 3,0,0,0);
        add("lt_step",0,1,0,0,0,3,5,3,2, 4,0,0,0);
        // max_val = 0 in every mode
        add("z_rst",  1,1,0,0,0,0,0,1,0, 0,0,0,0);
        add("z_up",   0,1,0,0,0,0,0,1,0, 0,0,1,0);
        add("z_up2",  0,1,0,0,0,0,0,1,0, 0,0,1,0);
        add("z_upsat",0,1,0,1,0,0,0,1,0, 0,0,1,0);
        add("z_dn",   0,1,1,0,0,0,0,1,0, 0,1,1,0);
        add("z_dnsat",0,1,1,1,0,0,0,1,0, 0,1,1,0);
        add("z_bn1",  0,1,2,0,0,0,0,1,0, 0,0,1,0);
        add("z_bn2",  0,1,2,0,0,0,0,1,0, 0,1,1,0);
        add("z_hold", 0,1,3,0,0,0,0,1,0, 0,1,0,0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            sat = vecs[i].sat; load = vecs[i].load;
            load_val = vecs[i].lv; max_val = vecs[i].mx;
            cmp_val = vecs[i].cv; presc = vecs[i].pr;
            tick_clk();
            chk(vecs[i].nm, int'(vecs[i].ec), int'(vecs[i].ed),
                int'(vecs[i].et), int'(vecs[i].em));
        end

        // Prescale by 3 with saturation, then freeze with en=0
        rst = 1; en = 1; mode = 0; sat = 1; load = 0;
        max_val = 3; cmp_val = 9; presc = 2;
        tick_clk();
        chk("ps_rst", 0, 0, 0, 0);
        rst = 0;
        for (int c = 1; c <= 12; c++) begin
            tick_clk();
            chk($sformatf("ps_c%0d", c), (c / 3 > 3) ? 3 : c / 3,
                0, (c == 12) ? 1 : 0, 0);
        end
        en = 0;
        for (int c = 0; c < 4; c++) begin
            tick_clk();
            chk("ps_frz", 3, 0, 0, 0);
        end
        en = 1;
        for (int c = 1; c <= 3; c++) begin
            tick_clk();
            chk("ps_sathold", 3, 0, (c == 3) ? 1 : 0, 0);
        end

        // Full-range free-running wrap
        mode = 0; sat = 0; max_val = 255; cmp_val = 0; presc = 0;
        load = 1; load_val = 254;
        tick_clk();
        chk("w_ld254", 254, 0, 0, 0);
        load = 0;
        tick_clk();
        chk("w_255", 255, 0, 0, 0);
        tick_clk();
        chk("w_wrap", 0, 0, 1, 1);
        tick_clk();
        chk("w_1", 1, 0, 0, 0);

        // Randomized run against the reference model
        rst = 1; load = 0; en = 1;
        tick_clk();
        model_step();
        chk("rnd_rst", m_count, m_dir, m_tc, m_cmp);
        max_val = 6; cmp_val = 3; presc = 1; mode = 0; sat = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 19) == 0);
            load_val = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    max_val = $urandom_range(0, 1) ? 8'd255 : 8'd0;
                else
                    max_val = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 15) == 0)
                cmp_val = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0)
                presc = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0)
                mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0)
                sat = 1'($urandom_range(0, 1));
            tick_clk();
            model_step();
            chk("rnd", m_count, m_dir, m_tc, m_cmp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
